// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that reuses one full-adder slice over WIDTH clocks, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             Ovf
`endif
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
   logic [CW-1:0] cnt;
   logic c, s, co, last;
   assign s      = a_sh[0] ^ b_sh[0] ^ c;
   assign co     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
   assign res_nx = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
   assign last   = cnt == CW'(WIDTH - 1);
   assign Busy   = state != IDLE;
   assign Done   = state == DONE;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) state <= IDLE;
      else     state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (Start ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN)  : IDLE;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         cnt  <= '0;
         c    <= 1'b0;
         Sum  <= '0;
         Cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         Ovf  <= 1'b0;
`endif
      end else if (state == IDLE && Start) begin
         a_sh <= A;
         b_sh <= B;
         c    <= Cin;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         c    <= co;
         res  <= res_nx;
         cnt  <= cnt + 1'b1;
         if (last) begin
            Sum  <= res_nx;
            Cout <= co;
`ifdef SERIAL_ADD_OVF_EN
            // on the last step c is the carry into the MSB, co the carry out of it
            Ovf  <= c ^ co;
`endif
         end
      end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
   logic [0:0] a1 = '0, b1 = '0, sum1;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf8, ovf1;
`endif

   serial_adder_ctrl #(.WIDTH(8)) u8 (
      .Clk(clk), .Rst(rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8),
      .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
      , .Ovf(ovf8)
`endif
   );

   serial_adder_ctrl #(.WIDTH(1)) u1 (
      .Clk(clk), .Rst(rst), .Start(start1), .A(a1), .B(b1), .Cin(cin1),
      .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
      , .Ovf(ovf1)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] sb8[$];
   logic [1:0] sb1[$];

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, b} + {8'b0, ci};
      return {(a[7] == b[7]) && (t[7] != a[7]), t};
   endfunction

   function automatic logic [9:0] observed8();
`ifdef SERIAL_ADD_OVF_EN
      return {ovf8, cout8, sum8};
`else
      return {1'b0, cout8, sum8};
`endif
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      output logic [9:0] got, output int lat, output logic busy_gap);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
      sb8.push_back(model8(a, b, ci));
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~ci;
      lat = 0;
      busy_gap = !busy8;
      while (!done8 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!busy8) busy_gap = 1'b1;
      end
      got = observed8();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy8, done8, cout8, sum8} !== 11'b0) begin
         n_bad++;
         $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h expected all zero", busy8, done8, cout8, sum8);
      end
      n_cmp++;
      if ({busy1, done1, cout1, sum1} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_state_w1: got busy=%b done=%b cout=%b sum=%b expected all zero", busy1, done1, cout1, sum1);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] ta[3] = '{8'h0F, 8'hFF, 8'hFF};
      logic [7:0] tb[3] = '{8'h01, 8'h01, 8'hFF};
      logic       tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] tx[3] = '{9'h010, 9'h100, 9'h1FF};
      logic [9:0] got, exp;
      int lat;
      logic gap;
      for (int i = 0; i < 3; i++) begin
         op8(ta[i], tb[i], tc[i], got, lat, gap);
         exp = sb8.pop_front();
         n_cmp++;
         if (got[8:0] !== exp[8:0] || got[8:0] !== tx[i]) begin
            n_bad++;
            $display("FAIL basic_%0d: got cout/sum=%h expected %h", i, got[8:0], tx[i]);
         end
         n_cmp++;
         if (lat != 8 || gap) begin
            n_bad++;
            $display("FAIL basic_latency_%0d: got lat=%0d busy_gap=%b expected lat=8 busy_gap=0", i, lat, gap);
         end
         @(negedge clk);
         n_cmp++;
         if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== tx[i]) begin
            n_bad++;
            $display("FAIL basic_after_%0d: got busy=%b done=%b cout/sum=%h expected 0 0 %h", i, busy8, done8, {cout8, sum8}, tx[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [9:0] got, exp;
      int lat, seen;
      logic gap;
      op8(8'h0F, 8'h01, 1'b0, got, lat, gap);
      exp = sb8.pop_front();
      n_cmp++;
      if (got[8:0] !== exp[8:0]) begin
         n_bad++;
         $display("FAIL midrst_pre: got %h expected %h", got[8:0], exp[8:0]);
      end
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_clear: got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy8, done8, sum8, cout8);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen);
      end
      op8(8'h0F, 8'h01, 1'b0, got, lat, gap);
      exp = sb8.pop_front();
      n_cmp++;
      if (got[8:0] !== exp[8:0] || lat != 8) begin
         n_bad++;
         $display("FAIL midrst_post: got %h lat=%0d expected %h lat=8", got[8:0], lat, exp[8:0]);
      end
   endtask

   task automatic test_truth_table();
      logic [2:0] v;
      logic [1:0] exp;
      int lat;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         @(negedge clk);
         start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
         sb1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
         @(negedge clk);
         start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
         lat = 0;
         while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         exp = sb1.pop_front();
         n_cmp++;
         if ({cout1, sum1} !== exp || lat != 1) begin
            n_bad++;
            $display("FAIL fa_%0d: got cout/sum=%b lat=%0d expected %b lat=1", i, {cout1, sum1}, lat, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp;
      logic [8:0] held = '0;
      int last_done = -1;
      int ndone = 0;
      int guard;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (done8) begin
            exp = sb8.size() > 0 ? sb8.pop_front() : 10'h3FF;
            n_cmp++;
            if ({cout8, sum8} !== exp[8:0]) begin
               n_bad++;
               $display("FAIL b2b_result: got %h expected %h", {cout8, sum8}, exp[8:0]);
            end
            if (last_done >= 0) begin
               n_cmp++;
               if (cyc - last_done != 10) begin
                  n_bad++;
                  $display("FAIL b2b_period: got %0d expected 10", cyc - last_done);
               end
            end
            last_done = cyc;
            held = {cout8, sum8};
            ndone++;
         end else if (last_done >= 0) begin
            n_cmp++;
            if ({cout8, sum8} !== held) begin
               n_bad++;
               $display("FAIL b2b_hold: got %h expected %h", {cout8, sum8}, held);
            end
         end
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         start8 = 1'b1;
         if (!busy8) sb8.push_back(model8(a8, b8, cin8));
      end
      @(negedge clk);
      start8 = 1'b0;
      guard = 0;
      while (sb8.size() > 0 && guard < 20) begin
         if (done8) begin
            exp = sb8.pop_front();
            n_cmp++;
            if ({cout8, sum8} !== exp[8:0]) begin
               n_bad++;
               $display("FAIL b2b_drain: got %h expected %h", {cout8, sum8}, exp[8:0]);
            end
         end
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (sb8.size() != 0 || ndone < 5) begin
         n_bad++;
         $display("FAIL b2b_count: got pending=%0d done=%0d expected pending=0 done>=5", sb8.size(), ndone);
      end
      sb8.delete();
   endtask

`ifdef SERIAL_ADD_OVF_EN
   task automatic test_ovf();
      logic [7:0] ta[3] = '{8'h7F, 8'h80, 8'h40};
      logic [7:0] tb[3] = '{8'h01, 8'h80, 8'h20};
      logic [1:0] tx[3] = '{2'b10, 2'b11, 2'b00};
      logic [9:0] got, exp;
      int lat;
      logic gap;
      for (int i = 0; i < 3; i++) begin
         op8(ta[i], tb[i], 1'b0, got, lat, gap);
         exp = sb8.pop_front();
         n_cmp++;
         if (got !== exp || got[9:8] !== tx[i]) begin
            n_bad++;
            $display("FAIL ovf_%0d: got ovf/cout/sum=%h expected %h", i, got, exp);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_reset_mid_run();
      test_truth_table();
      test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
      test_ovf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
